// File: rtl/regfile_if.sv
// Decode/writeback port bundle for the integer register file:
// two read ports and one write port.
interface regfile_if #(
    parameter int XLEN           = 64,
    parameter int REG_ADDR_WIDTH = 5
);
    logic [REG_ADDR_WIDTH-1:0] rs1_addr;
    logic [XLEN-1:0]           rs1_data;
    logic [REG_ADDR_WIDTH-1:0] rs2_addr;
    logic [XLEN-1:0]           rs2_data;
    logic                      rd_wen;
    logic [REG_ADDR_WIDTH-1:0] rd_addr;
    logic [XLEN-1:0]           rd_data;

    modport master (
        output rs1_addr, rs2_addr, rd_wen, rd_addr, rd_data,
        input  rs1_data, rs2_data
    );

    modport slave (
        input  rs1_addr, rs2_addr, rd_wen, rd_addr, rd_data,
        output rs1_data, rs2_data
    );
endinterface

// File: rtl/regfile.sv
// RV64 integer register file: x0 hardwired to zero, two combinational read
// ports with write-through bypass, one synchronous write port.
module regfile_rdport #(
    parameter int XLEN           = 64,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic [2**REG_ADDR_WIDTH-1:0][XLEN-1:0] i_regs,
    input  logic                                   i_rst,
    input  logic                                   i_byp_en,
    input  logic [REG_ADDR_WIDTH-1:0]              i_waddr,
    input  logic [XLEN-1:0]                        i_wdata,
    input  logic [REG_ADDR_WIDTH-1:0]              i_raddr,
    output logic [XLEN-1:0]                        o_rdata
);
    always_comb begin
        o_rdata = i_regs[i_raddr];
        if (i_byp_en && (i_raddr == i_waddr))
            o_rdata = i_wdata;
        // Bypass must not leak write data while reset holds the file at zero.
        if (i_rst)
            o_rdata = '0;
    end
endmodule

module regfile #(
    parameter int XLEN           = 64,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic       clk,
    input  logic       rst,
    regfile_if.slave   bus
);
    localparam int NREGS  = 2**REG_ADDR_WIDTH;
    localparam int NPORTS = 2;

    logic [NREGS-1:1][XLEN-1:0]          r_regs;
    logic [NREGS-1:0][XLEN-1:0]          w_regs;
    logic                                w_wr;
    logic [NPORTS-1:0][REG_ADDR_WIDTH-1:0] w_raddr;
    logic [NPORTS-1:0][XLEN-1:0]         w_rdata;

    assign w_wr = bus.rd_wen && (bus.rd_addr != '0);

    for (genvar g = 1; g < NREGS; g++) begin : g_reg
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                r_regs[g] <= '0;
            else if (w_wr && (bus.rd_addr == REG_ADDR_WIDTH'(g)))
                r_regs[g] <= bus.rd_data;
        end
    end

    // Entry 0 has no storage; it is a constant zero row in the read view.
    assign w_regs[0]         = '0;
    assign w_regs[NREGS-1:1] = r_regs;

    assign w_raddr = {bus.rs2_addr, bus.rs1_addr};

    for (genvar p = 0; p < NPORTS; p++) begin : g_rd
        regfile_rdport #(
            .XLEN           (XLEN),
            .REG_ADDR_WIDTH (REG_ADDR_WIDTH)
        ) u_rdport (
            .i_regs   (w_regs),
            .i_rst    (rst),
            .i_byp_en (w_wr),
            .i_waddr  (bus.rd_addr),
            .i_wdata  (bus.rd_data),
            .i_raddr  (w_raddr[p]),
            .o_rdata  (w_rdata[p])
        );
    end

    assign bus.rs1_data = w_rdata[0];
    assign bus.rs2_data = w_rdata[1];
endmodule

// File: tb/tb_regfile.sv
// Directed bench for regfile: writes, x0 handling, bypass, async reset.
module tb_regfile;
    localparam int XLEN = 64;
    localparam int AW   = 5;
    localparam logic [XLEN-1:0] PAT = 64'h0101010101010101;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    regfile_if #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW)) u_if ();

    regfile #(.XLEN(XLEN), .REG_ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        @(negedge clk);
        u_if.rd_wen  = 1'b1;
        u_if.rd_addr = a;
        u_if.rd_data = d;
        @(posedge clk);
        #1;
        u_if.rd_wen  = 1'b0;
    endtask

    task automatic rd2(input string tag, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                       input logic [XLEN-1:0] e1, input logic [XLEN-1:0] e2);
        u_if.rs1_addr = a1;
        u_if.rs2_addr = a2;
        #1;
        chk({tag, "_rs1"}, u_if.rs1_data, e1);
        chk({tag, "_rs2"}, u_if.rs2_data, e2);
    endtask

    initial begin
        rst           = 1'b1;
        u_if.rd_wen   = 1'b0;
        u_if.rd_addr  = '0;
        u_if.rd_data  = '0;
        u_if.rs1_addr = '0;
        u_if.rs2_addr = '0;
        #1;
        rd2("reset_state", 5'd5, 5'd31, 64'h0, 64'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        wr(5'd1, 64'hDEADBEEFCAFEBABE);
        rd2("x1_write", 5'd1, 5'd0, 64'hDEADBEEFCAFEBABE, 64'h0);

        wr(5'd0, 64'hFFFFFFFFFFFFFFFF);
        rd2("x0_discard", 5'd0, 5'd0, 64'h0, 64'h0);

        wr(5'd2, 64'h1111111111111111);
        wr(5'd3, 64'h2222222222222222);
        rd2("b2b_diff", 5'd2, 5'd3, 64'h1111111111111111, 64'h2222222222222222);

        // rd_wen low must leave x3 untouched despite address/data activity
        @(negedge clk);
        u_if.rd_addr = 5'd3;
        u_if.rd_data = 64'h0BADF00D0BADF00D;
        @(posedge clk);
        #1;
        rd2("wen_low", 5'd3, 5'd3, 64'h2222222222222222, 64'h2222222222222222);

        for (int i = 1; i < 32; i++)
            wr(AW'(i), PAT * XLEN'(i));
        for (int i = 0; i < 32; i++)
            rd2($sformatf("fill_x%0d", i), AW'(i), AW'(31 - i),
                PAT * XLEN'(i), PAT * XLEN'(31 - i));

        wr(5'd9, 64'h1234567812345678);
        wr(5'd9, 64'h8765432187654321);
        rd2("last_wins", 5'd9, 5'd0, 64'h8765432187654321, 64'h0);

        // Same-cycle bypass, before the edge
        @(negedge clk);
        u_if.rd_wen  = 1'b1;
        u_if.rd_addr = 5'd5;
        u_if.rd_data = 64'hA5A5A5A5A5A5A5A5;
        rd2("bypass_both", 5'd5, 5'd5, 64'hA5A5A5A5A5A5A5A5, 64'hA5A5A5A5A5A5A5A5);
        rd2("bypass_one", 5'd5, 5'd6, 64'hA5A5A5A5A5A5A5A5, PAT * 64'd6);
        u_if.rd_wen = 1'b0;
        rd2("bypass_off", 5'd5, 5'd5, PAT * 64'd5, PAT * 64'd5);
        u_if.rd_wen  = 1'b1;
        u_if.rd_addr = 5'd0;
        u_if.rd_data = 64'hFFFFFFFFFFFFFFFF;
        rd2("bypass_x0", 5'd0, 5'd0, 64'h0, 64'h0);
        u_if.rd_wen = 1'b0;

        wr(5'd5, 64'hA5A5A5A5A5A5A5A5);
        rd2("bypass_commit", 5'd5, 5'd4, 64'hA5A5A5A5A5A5A5A5, PAT * 64'd4);

        // Asynchronous reset between edges
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        rd2("async_rst", 5'd5, 5'd31, 64'h0, 64'h0);
        u_if.rd_wen  = 1'b1;
        u_if.rd_addr = 5'd7;
        u_if.rd_data = 64'h7777777777777777;
        rd2("rst_no_bypass", 5'd7, 5'd7, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        u_if.rd_wen = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rd2("rst_write_lost", 5'd7, 5'd1, 64'h0, 64'h0);

        wr(5'd7, 64'h7777777777777777);
        rd2("post_rst_write", 5'd7, 5'd8, 64'h7777777777777777, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
